xnor_match_detector: RTL and testbench
======================================

# xnor_match_detector

Parametrised successor to the two-input XNOR gate. Compares a WIDTH-bit input word bitwise (XNOR) against a programmable pattern with a per-bit don't-care mask, then registers the result. Counts consecutive matching samples and signals a hit once a programmable threshold is reached. Sits on a sampled data bus as a pattern/sync-word detector feeding control logic.

## Interface
- WIDTH, 8, compared word width (≥1)
- CNT_W, 4, width of run counter and threshold (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cfg_we  input  1  load cfg_pattern/cfg_mask/cfg_thresh this cycle
- cfg_pattern  input  WIDTH  reference word
- cfg_mask  input  WIDTH  1 = bit is don't-care (always matches)
- cfg_thresh  input  CNT_W  consecutive matches required for hit; 0 treated as 1
- in_valid  input  1  in_data is a sample this cycle
- in_data  input  WIDTH  sample word
- eq_vec  output  WIDTH  registered per-bit result: ~(in_data ^ pattern) | mask
- match  output  1  registered: last accepted sample matched on all bits
- run_cnt  output  CNT_W  consecutive-match count, saturating
- hit  output  1  one-cycle pulse when run_cnt reaches threshold
- locked  output  1  level: threshold reached and no mismatch since

## Operation
- Config registers pattern, mask, thresh; reset values 0, 0, 1.
- Sample accepted when in_valid=1 and cfg_we=0. Bit-match vector bm = ~(in_data ^ pattern) | mask; word match wm = &bm.
- State machine (2 bits): IDLE (run_cnt=0), RUN (0<run_cnt<thresh_eff), LOCK (threshold reached).
  - IDLE/RUN: accepted wm=1 → run_cnt+1; if new count ≥ thresh_eff → LOCK, hit=1 for that cycle; else RUN.
  - Any state: accepted wm=0 → run_cnt=0, IDLE, locked=0.
  - LOCK: accepted wm=1 → run_cnt increments, saturating at 2^CNT_W−1; no further hit pulses.
  - No accepted sample: state, run_cnt, eq_vec, match held; hit=0.
- thresh_eff = (thresh==0) ? 1 : thresh.
- cfg_we=1: loads config; clears run_cnt, match, locked, hit; state → IDLE; eq_vec held. Concurrent in_valid sample is dropped.
- locked = (state==LOCK).
- Mask bit set forces eq_vec bit to 1 regardless of in_data.
- All-ones mask: every accepted sample matches.

## Timing
- Reset (rst_n low, asynchronous): eq_vec=0, match=0, run_cnt=0, hit=0, locked=0, state IDLE, config at reset values. Takes effect immediately, mid-run included; first accepted sample after release is evaluated against reset config.
- Latency 1: sample accepted at edge N → eq_vec, match, run_cnt, hit, locked valid after edge N.
- hit is high exactly one cycle, in the same cycle locked first goes high.
- Config loaded at edge N applies to samples accepted from edge N+1 on.
- in_valid gaps do not break a run; only a mismatching accepted sample or cfg_we does.
- Saturation: at run_cnt=2^CNT_W−1, further matches hold the count; no wrap.

## Test plan
- Reset mid-run: run_cnt=3 with locked=1, pulse rst_n low mid-cycle → all outputs 0 immediately; pattern back to 0x00, thresh 1.
- Basic compare: pattern=0xA5, mask=0x00, thresh=1; in_data=0xA5 → next cycle eq_vec=0xFF, match=1, hit=1 (one cycle), locked=1; in_data=0xA4 → eq_vec=0xFE, match=0, run_cnt=0, locked=0.
- Mask: pattern=0xF0, mask=0x0F; in_data=0xF3 → eq_vec=0xFF, match=1; in_data=0x73 → eq_vec=0x7F, match=0.
- Threshold with gaps: thresh=3, three matching samples separated by in_valid=0 cycles → run_cnt 1,2,3, hit pulses only on the third, locked stays high until mismatch; thresh=0 behaves as 1.
- Saturation: CNT_W=4, thresh=2, 20 consecutive matches → run_cnt stops at 15, single hit pulse total.
- Config collision: cfg_we=1 and in_valid=1 together during LOCK → run_cnt=0, locked=0, match=0, sample ignored; next sample compared against new pattern.

Source files
------------

// File: rtl/xnor_match_detector.sv
// xnor_match_detector
//
// Bitwise XNOR pattern matcher with a per-bit don't-care mask. It registers the
// per-bit and whole-word result of each accepted sample and counts consecutive
// matching samples. When the count reaches a programmable threshold it pulses
// hit and holds locked.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   cfg_we       load cfg_pattern/cfg_mask/cfg_thresh; clears the run and drops any sample
//   cfg_pattern  reference word
//   cfg_mask     1 = don't-care bit (always matches)
//   cfg_thresh   consecutive matches required for hit (0 behaves as 1)
//   in_valid     in_data carries a sample this cycle
//   in_data      sample word
//   eq_vec       registered per-bit match vector
//   match        registered whole-word match of the last accepted sample
//   run_cnt      consecutive-match count, saturating
//   hit          one-cycle pulse when the threshold is first reached
//   locked       threshold reached and no mismatch since
module xnor_match_detector #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_pattern,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] eq_vec,
  output logic             match,
  output logic [CNT_W-1:0] run_cnt,
  output logic             hit,
  output logic             locked
);

  typedef enum logic [1:0] {StIdle, StRun, StLock} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] eq_q, eq_d;
  logic             match_q, match_d;
  logic             hit_q, hit_d;

  logic [WIDTH-1:0] bm;
  logic             wm;
  logic [CNT_W-1:0] thresh_eff;
  logic [CNT_W:0]   cnt_inc;

  assign bm         = ~(in_data ^ pattern_q) | mask_q;
  assign wm         = &bm;
  assign thresh_eff = (thresh_q == '0) ? CntOne : thresh_q;
  // One bit wider so the compare against thresh_eff never sees a wrapped value.
  assign cnt_inc    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    mask_d    = mask_q;
    thresh_d  = thresh_q;
    cnt_d     = cnt_q;
    eq_d      = eq_q;
    match_d   = match_q;
    hit_d     = 1'b0;

    if (cfg_we) begin
      // Config load wins over a concurrent sample; eq_vec deliberately holds.
      pattern_d = cfg_pattern;
      mask_d    = cfg_mask;
      thresh_d  = cfg_thresh;
      cnt_d     = '0;
      match_d   = 1'b0;
      state_d   = StIdle;
    end else if (in_valid) begin
      eq_d    = bm;
      match_d = wm;
      if (!wm) begin
        cnt_d   = '0;
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle, StRun: begin
            // Outside LOCK the count is below thresh_eff, so it cannot overflow.
            cnt_d = cnt_inc[CNT_W-1:0];
            if (cnt_inc >= {1'b0, thresh_eff}) begin
              state_d = StLock;
              hit_d   = 1'b1;
            end else begin
              state_d = StRun;
            end
          end
          StLock: begin
            if (cnt_q != CntMax) begin
              cnt_d = cnt_inc[CNT_W-1:0];
            end
          end
          default: begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      mask_q    <= '0;
      thresh_q  <= CntOne;
      cnt_q     <= '0;
      eq_q      <= '0;
      match_q   <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      mask_q    <= mask_d;
      thresh_q  <= thresh_d;
      cnt_q     <= cnt_d;
      eq_q      <= eq_d;
      match_q   <= match_d;
      hit_q     <= hit_d;
    end
  end

  assign eq_vec  = eq_q;
  assign match   = match_q;
  assign run_cnt = cnt_q;
  assign hit     = hit_q;
  assign locked  = (state_q == StLock);

endmodule

// File: tb/tb_xnor_match_detector.sv
module tb_xnor_match_detector;

  typedef struct packed {
    logic [7:0] eq;
    logic       m;
    logic [3:0] cnt;
    logic       h;
    logic       l;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [7:0] cfg_mask;
  logic [3:0] cfg_thresh;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] eq_vec;
  logic       match;
  logic [3:0] run_cnt;
  logic       hit;
  logic       locked;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  xnor_match_detector #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_mask   (cfg_mask),
    .cfg_thresh (cfg_thresh),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .eq_vec     (eq_vec),
    .match      (match),
    .run_cnt    (run_cnt),
    .hit        (hit),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] eq, input logic m, input logic [3:0] cnt,
                              input logic h, input logic l);
    exp_t e;
    e.eq = eq; e.m = m; e.cnt = cnt; e.h = h; e.l = l;
    return e;
  endfunction

  task automatic compare(input string name, input exp_t e);
    exp_t a;
    a = mk(eq_vec, match, run_cnt, hit, locked);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got eq=%h m=%b cnt=%0d hit=%b lock=%b, want eq=%h m=%b cnt=%0d hit=%b lock=%b",
               name, a.eq, a.m, a.cnt, a.h, a.l, e.eq, e.m, e.cnt, e.h, e.l);
    end
  endtask

  // Monitor: outputs settle just after each edge; one queued expectation per driven cycle.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) compare("scoreboard", exp_q.pop_front());
  end

  // Drive one cycle and queue the hand-computed outputs expected after the next edge.
  task automatic step(input logic we, input logic [7:0] pat, input logic [7:0] msk,
                      input logic [3:0] thr, input logic v, input logic [7:0] d,
                      input logic [7:0] eq, input logic m, input logic [3:0] cnt,
                      input logic h, input logic l);
    @(negedge clk);
    cfg_we = we; cfg_pattern = pat; cfg_mask = msk; cfg_thresh = thr;
    in_valid = v; in_data = d;
    exp_q.push_back(mk(eq, m, cnt, h, l));
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [7:0] msk, input logic [3:0] thr,
                     input logic [7:0] eq);
    step(1'b1, pat, msk, thr, 1'b0, 8'h00, eq, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic smp(input logic [7:0] d, input logic [7:0] eq, input logic m,
                     input logic [3:0] cnt, input logic h, input logic l);
    step(1'b0, 8'h00, 8'h00, 4'd0, 1'b1, d, eq, m, cnt, h, l);
  endtask

  task automatic gap(input logic [7:0] eq, input logic m, input logic [3:0] cnt, input logic l);
    step(1'b0, 8'h00, 8'h00, 4'd0, 1'b0, 8'h00, eq, m, cnt, 1'b0, l);
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_mask = '0; cfg_thresh = '0;
    in_valid = 1'b0; in_data = '0;
    #1 compare("reset_state", mk(8'h00, 1'b0, 4'd0, 1'b0, 1'b0));
    @(negedge clk) rst_n = 1'b1;

    // Basic compare
    cfg(8'hA5, 8'h00, 4'd1, 8'h00);
    smp(8'hA5, 8'hFF, 1'b1, 4'd1, 1'b1, 1'b1);
    gap(8'hFF, 1'b1, 4'd1, 1'b1);
    smp(8'hA4, 8'hFE, 1'b0, 4'd0, 1'b0, 1'b0);

    // Mask
    cfg(8'hF0, 8'h0F, 4'd1, 8'hFE);
    smp(8'hF3, 8'hFF, 1'b1, 4'd1, 1'b1, 1'b1);
    smp(8'h73, 8'h7F, 1'b0, 4'd0, 1'b0, 1'b0);

    // Threshold 3 with in_valid gaps
    cfg(8'h3C, 8'h00, 4'd3, 8'h7F);
    smp(8'h3C, 8'hFF, 1'b1, 4'd1, 1'b0, 1'b0);
    gap(8'hFF, 1'b1, 4'd1, 1'b0);
    smp(8'h3C, 8'hFF, 1'b1, 4'd2, 1'b0, 1'b0);
    gap(8'hFF, 1'b1, 4'd2, 1'b0);
    gap(8'hFF, 1'b1, 4'd2, 1'b0);
    smp(8'h3C, 8'hFF, 1'b1, 4'd3, 1'b1, 1'b1);
    gap(8'hFF, 1'b1, 4'd3, 1'b1);
    smp(8'h3C, 8'hFF, 1'b1, 4'd4, 1'b0, 1'b1);
    smp(8'h3D, 8'hFE, 1'b0, 4'd0, 1'b0, 1'b0);

    // Threshold 0 acts as 1
    cfg(8'h3C, 8'h00, 4'd0, 8'hFE);
    smp(8'h3C, 8'hFF, 1'b1, 4'd1, 1'b1, 1'b1);

    // Saturation at 15, single hit
    cfg(8'h55, 8'h00, 4'd2, 8'hFF);
    for (int i = 0; i < 20; i++) begin
      smp(8'h55, 8'hFF, 1'b1, (i >= 14) ? 4'd15 : 4'(i + 1), (i == 1), (i >= 1));
    end

    // Config collision during LOCK: sample dropped, new pattern applies next
    step(1'b1, 8'hAA, 8'h00, 4'd1, 1'b1, 8'h55, 8'hFF, 1'b0, 4'd0, 1'b0, 1'b0);
    smp(8'h55, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    smp(8'hAA, 8'hFF, 1'b1, 4'd1, 1'b1, 1'b1);

    // All-ones mask matches anything
    cfg(8'h00, 8'hFF, 4'd2, 8'hFF);
    smp(8'h12, 8'hFF, 1'b1, 4'd1, 1'b0, 1'b0);
    smp(8'h34, 8'hFF, 1'b1, 4'd2, 1'b1, 1'b1);

    // Reset mid-run at run_cnt=3, locked
    cfg(8'h0F, 8'h00, 4'd2, 8'hFF);
    smp(8'h0F, 8'hFF, 1'b1, 4'd1, 1'b0, 1'b0);
    smp(8'h0F, 8'hFF, 1'b1, 4'd2, 1'b1, 1'b1);
    smp(8'h0F, 8'hFF, 1'b1, 4'd3, 1'b0, 1'b1);
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 compare("async_reset", mk(8'h00, 1'b0, 4'd0, 1'b0, 1'b0));
    @(negedge clk) rst_n = 1'b1;
    // Reset config: pattern 0x00, mask 0, thresh 1
    smp(8'h00, 8'hFF, 1'b1, 4'd1, 1'b1, 1'b1);
    smp(8'h01, 8'hFE, 1'b0, 4'd0, 1'b0, 1'b0);

    @(negedge clk) in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
